// File: rtl/pmem_arbiter.sv
// Arbitrates one cacheline memory port between the I-cache and D-cache miss/writeback paths.
// Latency: request sampled at edge k drives mem_read/mem_write from edge k; resp is returned combinationally.
// Backpressure: requests are held by the caches until their resp pulse; one RECOVER cycle follows every transaction.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;   // 0 = I-cache served last, 1 = D-cache
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic                w_i_req;
  logic                w_d_req;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_busy_done;

  assign w_i_req     = i_pmem_read;
  assign w_d_req     = d_pmem_read | d_pmem_write;
  assign w_busy_done = ((r_state == I_BUSY) || (r_state == D_BUSY)) && mem_resp;

  // State register; reset lands in IDLE at once, even mid-transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next state and grant decision; ties go to whoever was not served last.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req && (!w_d_req || r_last_grant)) begin
          w_grant_i    = 1'b1;
          w_next_state = I_BUSY;
        end else if (w_d_req) begin
          w_grant_d    = 1'b1;
          w_next_state = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) w_next_state = RECOVER;
      end
      // One dead cycle lets the served cache drop its request before re-arbitration.
      RECOVER: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the granted command for the whole transaction; clear commands on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant  <= 1'b1;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else if (w_grant_i) begin
      r_last_grant  <= 1'b0;
      r_mem_read    <= 1'b1;
      r_mem_write   <= 1'b0;
      r_mem_address <= i_pmem_address;
    end else if (w_grant_d) begin
      // Read and write together is illegal; the writeback goes first.
      r_last_grant  <= 1'b1;
      r_mem_read    <= ~d_pmem_write;
      r_mem_write   <= d_pmem_write;
      r_mem_address <= d_pmem_address;
      r_mem_wdata   <= d_pmem_wdata;
    end else if (w_busy_done) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  // Response and data are steered only to the side that currently owns the port.
  assign i_pmem_resp  = (r_state == I_BUSY) && mem_resp;
  assign d_pmem_resp  = (r_state == D_BUSY) && mem_resp;
  assign i_pmem_rdata = (r_state == I_BUSY) ? mem_rdata : '0;
  assign d_pmem_rdata = (r_state == D_BUSY) ? mem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: grant, routing, round-robin, recover cycle, async reset.
// Inputs change just after the falling edge; outputs are sampled on the falling edge or 1 ns later.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [LINE_W-1:0] WB  = {8{32'hA5A5_A5A5}};
  localparam logic [LINE_W-1:0] RD1 = {8{32'h1111_2222}};
  localparam logic [LINE_W-1:0] RD2 = {8{32'h3333_4444}};
  localparam logic [LINE_W-1:0] RD3 = {8{32'h5555_6666}};
  localparam logic [LINE_W-1:0] ZL  = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %0b exp 0", mem_read); end
    n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %0b exp 0", mem_write); end
    n_chk++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL rst_mem_address: got %h exp 0", mem_address); end
    n_chk++; if (mem_wdata !== ZL) begin n_fail++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL rst_resp: got %b exp 00", {i_pmem_resp, d_pmem_resp}); end
    n_chk++; if ((i_pmem_rdata | d_pmem_rdata) !== ZL) begin n_fail++; $display("FAIL rst_rdata: got nonzero exp 0"); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_only;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ionly_mem_read: got %0b exp 1", mem_read); end
    n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL ionly_mem_write: got %0b exp 0", mem_write); end
    n_chk++; if (mem_address !== 32'h0000_1000) begin n_fail++; $display("FAIL ionly_addr: got %h exp 00001000", mem_address); end
    n_chk++; if (i_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL ionly_early_resp: got %0b exp 0", i_pmem_resp); end
    i_pmem_address = 32'hDEAD_0000;
    @(negedge clk);
    i_pmem_read = 1'b0;   // dropped mid-transaction: must still complete
    n_chk++; if (mem_address !== 32'h0000_1000) begin n_fail++; $display("FAIL ionly_addr_held: got %h exp 00001000", mem_address); end
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ionly_read_held: got %0b exp 1", mem_read); end
    mem_resp = 1'b1; mem_rdata = RD1;
    #1;
    n_chk++; if (i_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL ionly_resp: got %0b exp 1", i_pmem_resp); end
    n_chk++; if (i_pmem_rdata !== RD1) begin n_fail++; $display("FAIL ionly_rdata: got %h exp %h", i_pmem_rdata, RD1); end
    n_chk++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL ionly_d_resp: got %0b exp 0", d_pmem_resp); end
    n_chk++; if (d_pmem_rdata !== ZL) begin n_fail++; $display("FAIL ionly_d_rdata: got %h exp 0", d_pmem_rdata); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_address = '0;
    #1;
    n_chk++; if (i_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL ionly_resp_pulse: got %0b exp 0", i_pmem_resp); end
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL ionly_read_clr: got %0b exp 0", mem_read); end
    @(negedge clk);
  endtask

  task automatic test_d_writeback;
    d_pmem_write = 1'b1; d_pmem_read = 1'b1;   // illegal combo: write must win
    d_pmem_address = 32'h0000_2040; d_pmem_wdata = WB;
    @(negedge clk);
    n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wb_mem_write: got %0b exp 1", mem_write); end
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL wb_mem_read: got %0b exp 0", mem_read); end
    n_chk++; if (mem_address !== 32'h0000_2040) begin n_fail++; $display("FAIL wb_addr: got %h exp 00002040", mem_address); end
    n_chk++; if (mem_wdata !== WB) begin n_fail++; $display("FAIL wb_wdata: got %h exp %h", mem_wdata, WB); end
    d_pmem_wdata = '0; d_pmem_address = '0;
    @(negedge clk);
    n_chk++; if (mem_wdata !== WB) begin n_fail++; $display("FAIL wb_wdata_held: got %h exp %h", mem_wdata, WB); end
    mem_resp = 1'b1; mem_rdata = RD2;
    #1;
    n_chk++; if (d_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL wb_d_resp: got %0b exp 1", d_pmem_resp); end
    n_chk++; if (i_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL wb_i_resp: got %0b exp 0", i_pmem_resp); end
    n_chk++; if (d_pmem_rdata !== RD2) begin n_fail++; $display("FAIL wb_d_rdata: got %h exp %h", d_pmem_rdata, RD2); end
    n_chk++; if (i_pmem_rdata !== ZL) begin n_fail++; $display("FAIL wb_i_rdata: got %h exp 0", i_pmem_rdata); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b0;
    #1;
    n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL wb_write_clr: got %0b exp 0", mem_write); end
    n_chk++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL wb_resp_pulse: got %0b exp 0", d_pmem_resp); end
    @(negedge clk);
  endtask

  task automatic test_tie_round_robin;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5000;
    @(negedge clk);
    n_chk++; if (mem_address !== 32'h0000_4000) begin n_fail++; $display("FAIL tie1_addr: got %h exp 00004000", mem_address); end
    n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL tie1_read: got %0b exp 1", mem_read); end
    mem_resp = 1'b1; mem_rdata = RD1;
    #1;
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL tie1_resp: got %b exp 10", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tie_recover_read: got %0b exp 0", mem_read); end
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tie_no_early_grant: got %0b exp 0", mem_read); end
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL tie2_read: got %0b exp 1", mem_read); end
    n_chk++; if (mem_address !== 32'h0000_5000) begin n_fail++; $display("FAIL tie2_addr: got %h exp 00005000", mem_address); end
    mem_resp = 1'b1; mem_rdata = RD2;
    #1;
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL tie2_resp: got %b exp 01", {i_pmem_resp, d_pmem_resp}); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b1;   // D keeps requesting: both tie again
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (mem_address !== 32'h0000_4000) begin n_fail++; $display("FAIL tie3_addr: got %h exp 00004000", mem_address); end
    mem_resp = 1'b1;
    #1;
    n_chk++; if (i_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL tie3_resp: got %0b exp 1", i_pmem_resp); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = WB;
    @(negedge clk);
    n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL b2b_write: got %0b exp 1", mem_write); end
    mem_resp = 1'b1;
    #1;
    n_chk++; if (d_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL b2b_wb_resp: got %0b exp 1", d_pmem_resp); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    #1;
    n_chk++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL b2b_recover: got %b exp 00", {mem_read, mem_write}); end
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0b exp 0", mem_read); end
    @(negedge clk);
    n_chk++; if ({mem_read, mem_write} !== 2'b10) begin n_fail++; $display("FAIL b2b_fill_cmd: got %b exp 10", {mem_read, mem_write}); end
    n_chk++; if (mem_address !== 32'h0000_3000) begin n_fail++; $display("FAIL b2b_fill_addr: got %h exp 00003000", mem_address); end
    mem_resp = 1'b1; mem_rdata = RD3;
    #1;
    n_chk++; if (d_pmem_rdata !== RD3) begin n_fail++; $display("FAIL b2b_fill_rdata: got %h exp %h", d_pmem_rdata, RD3); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_resp;
    mem_resp = 1'b1; mem_rdata = RD1;
    #1;
    n_chk++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL spur_resp: got %b exp 00", {i_pmem_resp, d_pmem_resp}); end
    n_chk++; if ((i_pmem_rdata | d_pmem_rdata) !== ZL) begin n_fail++; $display("FAIL spur_rdata: got nonzero exp 0"); end
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
    n_chk++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL spur_no_cmd: got %0b exp 0", mem_read); end
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_6000) begin n_fail++; $display("FAIL spur_still_idle: got read=%0b addr=%h exp read=1 addr=00006000", mem_read, mem_address); end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_7000; d_pmem_wdata = WB;
    @(negedge clk);
    n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL arst_pre_write: got %0b exp 1", mem_write); end
    #2;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = RD1;
    #1;
    n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL arst_write: got %0b exp 0", mem_write); end
    n_chk++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL arst_addr: got %h exp 0", mem_address); end
    n_chk++; if (mem_wdata !== ZL) begin n_fail++; $display("FAIL arst_wdata: got %h exp 0", mem_wdata); end
    n_chk++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL arst_resp: got %0b exp 0", d_pmem_resp); end
    n_chk++; if (d_pmem_rdata !== ZL) begin n_fail++; $display("FAIL arst_rdata: got %h exp 0", d_pmem_rdata); end
    @(negedge clk);
    mem_resp = 1'b0; d_pmem_write = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL arst_post_cmd: got %b exp 00", {mem_read, mem_write}); end
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_8000;
    @(negedge clk);
    n_chk++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_8000) begin n_fail++; $display("FAIL arst_idle_grant: got read=%0b addr=%h exp read=1 addr=00008000", mem_read, mem_address); end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_writeback();
    test_tie_round_robin();
    test_back_to_back();
    test_spurious_resp();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
